// File: rtl/complete_stage.sv
// complete_stage: buffers functional-unit results in 2-entry per-FU queues,
// picks up to N_WAY of them per cycle round-robin, and emits registered CDB
// broadcasts that also drive the physical register file write ports.

`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef CDB_BITS
`define CDB_BITS 6
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ZERO_REG_PR
`define ZERO_REG_PR 0
`endif

module complete_stage #(
  parameter int N_FU     = 4,
  parameter int N_WAY    = `N_WAY,
  parameter int CDB_BITS = `CDB_BITS,
  parameter int XLEN     = `XLEN,
  parameter int ZERO_PR  = `ZERO_REG_PR
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               squash,
  input  logic [N_FU-1:0]                    fu_valid,
  input  logic [N_FU-1:0][CDB_BITS-1:0]      fu_tag,
  input  logic [N_FU-1:0][XLEN-1:0]          fu_data,
  output logic [N_FU-1:0]                    fu_ready,
  output logic [N_WAY-1:0]                   cdb_valid,
  output logic [N_WAY-1:0][CDB_BITS-1:0]     cdb_tag,
  output logic [N_WAY-1:0][CDB_BITS-1:0]     wr_idx,
  output logic [N_WAY-1:0][XLEN-1:0]         wr_data,
  output logic [N_WAY-1:0]                   wr_en
);

  localparam int PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1;
  localparam logic [CDB_BITS-1:0] ZERO_TAG = CDB_BITS'(ZERO_PR);

  // Per-FU queue: head entry is the one presented to the arbiter, tail is
  // the second slot that shifts into head on a pop.
  logic [N_FU-1:0][1:0]          count;
  logic [N_FU-1:0][CDB_BITS-1:0] head_tag;
  logic [N_FU-1:0][CDB_BITS-1:0] tail_tag;
  logic [N_FU-1:0][XLEN-1:0]     head_data;
  logic [N_FU-1:0][XLEN-1:0]     tail_data;
  logic [PTR_W-1:0]              rr_ptr;

  logic [N_FU-1:0]               push;
  logic [N_FU-1:0]               grant;
  logic [N_WAY-1:0]              sel_valid;
  logic [N_WAY-1:0][CDB_BITS-1:0] sel_tag;
  logic [N_WAY-1:0][XLEN-1:0]    sel_data;
  logic [PTR_W-1:0]              rr_next;

  // Ready depends only on the registered occupancy; a pop in the same cycle
  // does not free a slot early, so there is no path from fu_valid to ready.
  always_comb begin
    fu_ready = '0;
    push     = '0;
    for (int f = 0; f < N_FU; f++) begin
      fu_ready[f] = (count[f] < 2'd2);
      push[f]     = fu_valid[f] && (count[f] < 2'd2);
    end
  end

  // Round-robin scan starting at rr_ptr: the k-th non-empty queue found goes
  // to output slot k, and the pointer moves just past the last one granted.
  always_comb begin
    int n_grant;
    n_grant   = 0;
    grant     = '0;
    sel_valid = '0;
    sel_tag   = '0;
    sel_data  = '0;
    rr_next   = rr_ptr;
    for (int i = 0; i < N_FU; i++) begin
      for (int j = 0; j < N_FU; j++) begin
        if ((j == ((int'(rr_ptr) + i) % N_FU)) && (count[j] != 2'd0) && (n_grant < N_WAY)) begin
          grant[j] = 1'b1;
          for (int k = 0; k < N_WAY; k++) begin
            if (k == n_grant) begin
              sel_valid[k] = 1'b1;
              sel_tag[k]   = head_tag[j];
              sel_data[k]  = head_data[j];
            end
          end
          rr_next = PTR_W'((j + 1) % N_FU);
          n_grant = n_grant + 1;
        end
      end
    end
  end

  // Queue storage: pop shifts tail into head, push lands in the first free
  // slot after the pop; a squash simply forgets everything buffered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      head_tag  <= '0;
      tail_tag  <= '0;
      head_data <= '0;
      tail_data <= '0;
    end else if (squash) begin
      count <= '0;
    end else begin
      for (int f = 0; f < N_FU; f++) begin
        if (grant[f]) begin
          head_tag[f]  <= tail_tag[f];
          head_data[f] <= tail_data[f];
        end
        if (push[f]) begin
          if ((count[f] - {1'b0, grant[f]}) == 2'd0) begin
            head_tag[f]  <= fu_tag[f];
            head_data[f] <= fu_data[f];
          end else begin
            tail_tag[f]  <= fu_tag[f];
            tail_data[f] <= fu_data[f];
          end
        end
        count[f] <= count[f] + {1'b0, push[f]} - {1'b0, grant[f]};
      end
    end
  end

  // Arbitration pointer survives a squash so fairness is not reset by flushes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (!squash) begin
      rr_ptr <= rr_next;
    end
  end

  // Registered broadcast; the hardwired zero register is announced but never
  // written into the register file.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cdb_valid <= '0;
      cdb_tag   <= '0;
      wr_data   <= '0;
      wr_en     <= '0;
    end else if (squash) begin
      cdb_valid <= '0;
      cdb_tag   <= '0;
      wr_data   <= '0;
      wr_en     <= '0;
    end else begin
      cdb_valid <= sel_valid;
      cdb_tag   <= sel_tag;
      wr_data   <= sel_data;
      for (int k = 0; k < N_WAY; k++) begin
        wr_en[k] <= sel_valid[k] && (sel_tag[k] != ZERO_TAG);
      end
    end
  end

  assign wr_idx = cdb_tag;

endmodule

// File: tb/tb_complete_stage.sv
// tb_complete_stage: directed scenarios with a tag-keyed scoreboard; results
// are queued as they are accepted and retired as they appear on the CDB.

module tb_complete_stage;

  logic                 clock;
  logic                 reset_n;
  logic                 squash;
  logic [3:0]           fu_valid;
  logic [3:0][5:0]      fu_tag;
  logic [3:0][31:0]     fu_data;
  logic [3:0]           fu_ready;
  logic [1:0]           cdb_valid;
  logic [1:0][5:0]      cdb_tag;
  logic [1:0][5:0]      wr_idx;
  logic [1:0][31:0]     wr_data;
  logic [1:0]           wr_en;

  typedef struct packed {
    logic [5:0]  tag;
    logic [31:0] data;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int broadcasts = 0;
  int next_idx[4];

  complete_stage #(
    .N_FU(4), .N_WAY(2), .CDB_BITS(6), .XLEN(32), .ZERO_PR(0)
  ) dut (
    .clock(clock), .reset_n(reset_n), .squash(squash),
    .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_data(fu_data), .fu_ready(fu_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .wr_idx(wr_idx),
    .wr_data(wr_data), .wr_en(wr_en)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic setFu(input int f, input logic [5:0] tag, input logic [31:0] data);
    fu_valid[f] = 1'b1;
    fu_tag[f]   = tag;
    fu_data[f]  = data;
  endtask

  // Records what will be accepted at the next edge, crosses it, then drops
  // valid on accepted FUs while rejected ones keep holding their result.
  task automatic applyStimulus();
    logic [3:0] acc;
    sb_entry_t e;
    acc = fu_valid & fu_ready & {4{~squash}};
    for (int f = 0; f < 4; f++) begin
      if (acc[f]) begin
        e.tag  = fu_tag[f];
        e.data = fu_data[f];
        sb_q.push_back(e);
      end
    end
    @(posedge clock);
    #2;
    fu_valid = fu_valid & ~acc;
  endtask

  task automatic loadBackpressure();
    for (int f = 0; f < 4; f++) begin
      if (!fu_valid[f] && next_idx[f] < 3) begin
        setFu(f, 6'(32 + 4 * next_idx[f] + f), 32'hB000_0000 | 32'(32 + 4 * next_idx[f] + f));
        next_idx[f]++;
      end
    end
  endtask

  function automatic logic bpPending();
    logic p;
    p = (fu_valid != 4'b0) || (sb_q.size() != 0);
    for (int f = 0; f < 4; f++) if (next_idx[f] < 3) p = 1'b1;
    return p;
  endfunction

  // Launch one result per FU with tags base..base+3 and check the first pair.
  task automatic contentionRound(input logic [5:0] base);
    for (int f = 0; f < 4; f++) setFu(f, base + 6'(f), 32'hC000_0000 | 32'(base + 6'(f)));
    applyStimulus();
    checkOutput("contention_latency", 32'(cdb_valid), 32'h0);
    applyStimulus();
    checkOutput("contention_first_valid", 32'(cdb_valid), 32'h3);
    checkOutput("contention_first_tag0", 32'(cdb_tag[0]), 32'(base));
    checkOutput("contention_first_tag1", 32'(cdb_tag[1]), 32'(base + 6'd1));
  endtask

  task automatic contentionSecond(input logic [5:0] base);
    applyStimulus();
    checkOutput("contention_second_valid", 32'(cdb_valid), 32'h3);
    checkOutput("contention_second_tag0", 32'(cdb_tag[0]), 32'(base + 6'd2));
    checkOutput("contention_second_tag1", 32'(cdb_tag[1]), 32'(base + 6'd3));
    applyStimulus();
    checkOutput("contention_done", 32'(cdb_valid), 32'h0);
  endtask

  // Every broadcast must retire a queued result with matching write-port
  // values; idle slots must be all zero.
  always @(negedge clock) begin
    if (reset_n) begin
      for (int k = 0; k < 2; k++) begin
        int pos;
        pos = -1;
        if (cdb_valid[k]) begin
          for (int i = 0; i < sb_q.size(); i++) begin
            if (pos < 0 && sb_q[i].tag === cdb_tag[k]) pos = i;
          end
          checkOutput($sformatf("sb_known_tag[%0d]=%0h", k, cdb_tag[k]), 32'(pos >= 0), 32'h1);
          if (pos >= 0) begin
            checkOutput($sformatf("wr_idx[%0d]", k), 32'(wr_idx[k]), 32'(sb_q[pos].tag));
            checkOutput($sformatf("wr_data[%0d]", k), wr_data[k], sb_q[pos].data);
            checkOutput($sformatf("wr_en[%0d]", k), 32'(wr_en[k]), 32'(sb_q[pos].tag != 6'd0));
            sb_q.delete(pos);
            broadcasts++;
          end
        end else begin
          checkOutput($sformatf("idle_tag[%0d]", k), 32'(cdb_tag[k]), 32'h0);
          checkOutput($sformatf("idle_data[%0d]", k), wr_data[k], 32'h0);
          checkOutput($sformatf("idle_wr_en[%0d]", k), 32'(wr_en[k]), 32'h0);
        end
      end
    end
  end

  initial begin
    int bp_base;
    reset_n  = 1'b0;
    squash   = 1'b0;
    fu_valid = '0;
    fu_tag   = '0;
    fu_data  = '0;
    for (int f = 0; f < 4; f++) next_idx[f] = 0;

    // Reset state
    #12;
    checkOutput("reset_cdb_valid", 32'(cdb_valid), 32'h0);
    checkOutput("reset_wr_en", 32'(wr_en), 32'h0);
    checkOutput("reset_fu_ready", 32'(fu_ready), 32'hF);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    @(posedge clock);
    #2;
    checkOutput("post_reset_fu_ready", 32'(fu_ready), 32'hF);
    checkOutput("post_reset_cdb_valid", 32'(cdb_valid), 32'h0);

    // Contention, twice, to show the pointer comes back to FU0
    $display("[TB] contention");
    contentionRound(6'd1);
    contentionSecond(6'd1);
    contentionRound(6'd11);
    contentionSecond(6'd11);

    // Single result latency
    $display("[TB] single result");
    setFu(0, 6'd5, 32'h55);
    applyStimulus();
    checkOutput("single_latency", 32'(cdb_valid), 32'h0);
    applyStimulus();
    checkOutput("single_valid", 32'(cdb_valid), 32'h1);
    checkOutput("single_wr_idx", 32'(wr_idx[0]), 32'h5);
    checkOutput("single_wr_data", wr_data[0], 32'h55);
    checkOutput("single_wr_en", 32'(wr_en), 32'h1);
    applyStimulus();
    checkOutput("single_one_cycle", 32'(cdb_valid), 32'h0);

    // Zero register broadcast without write
    $display("[TB] zero register");
    setFu(1, 6'd0, 32'hDEAD);
    applyStimulus();
    applyStimulus();
    checkOutput("zero_valid", 32'(cdb_valid), 32'h1);
    checkOutput("zero_tag", 32'(cdb_tag[0]), 32'h0);
    checkOutput("zero_wr_en", 32'(wr_en), 32'h0);
    checkOutput("zero_data", wr_data[0], 32'hDEAD);
    applyStimulus();

    // FU3 alone, which also wraps the pointer back to 0
    setFu(3, 6'd7, 32'h77);
    applyStimulus();
    applyStimulus();
    checkOutput("fu3_valid", 32'(cdb_valid), 32'h1);
    checkOutput("fu3_tag", 32'(cdb_tag[0]), 32'h7);
    applyStimulus();

    // Backpressure: three results per FU, held while not ready
    $display("[TB] backpressure");
    bp_base = broadcasts;
    loadBackpressure();
    applyStimulus();
    loadBackpressure();
    applyStimulus();
    checkOutput("bp_fu_ready", 32'(fu_ready), 32'h3);
    for (int c = 0; c < 20 && bpPending(); c++) begin
      loadBackpressure();
      applyStimulus();
    end
    checkOutput("bp_drained", 32'(sb_q.size()), 32'h0);
    checkOutput("bp_broadcast_count", 32'(broadcasts - bp_base), 32'd12);

    // Squash with buffered entries and a new FU2 result in flight
    $display("[TB] squash");
    for (int f = 0; f < 4; f++) setFu(f, 6'(48 + f), 32'hE000_0000 | 32'(48 + f));
    applyStimulus();
    for (int f = 0; f < 4; f++) setFu(f, 6'(52 + f), 32'hE000_0000 | 32'(52 + f));
    applyStimulus();
    checkOutput("sq_fill_ready_a", 32'(fu_ready), 32'h3);
    setFu(0, 6'd56, 32'hE000_0038);
    setFu(1, 6'd57, 32'hE000_0039);
    applyStimulus();
    checkOutput("sq_fill_ready_b", 32'(fu_ready), 32'hC);
    checkOutput("sq_pre_tag0", 32'(cdb_tag[0]), 32'd50);
    checkOutput("sq_pre_tag1", 32'(cdb_tag[1]), 32'd51);
    squash = 1'b1;
    setFu(2, 6'd60, 32'hE000_003C);
    applyStimulus();
    squash   = 1'b0;
    fu_valid = '0;
    sb_q.delete();
    checkOutput("sq_cdb_valid", 32'(cdb_valid), 32'h0);
    checkOutput("sq_fu_ready", 32'(fu_ready), 32'hF);
    repeat (4) applyStimulus();
    checkOutput("sq_nothing_after", 32'(cdb_valid), 32'h0);

    // Asynchronous reset in the middle of a cycle with outputs live
    $display("[TB] mid-cycle reset");
    contentionRound(6'd21);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_cdb_valid", 32'(cdb_valid), 32'h0);
    checkOutput("async_reset_wr_en", 32'(wr_en), 32'h0);
    checkOutput("async_reset_fu_ready", 32'(fu_ready), 32'hF);
    sb_q.delete();
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    applyStimulus();
    checkOutput("after_reset_ready", 32'(fu_ready), 32'hF);
    checkOutput("after_reset_valid_a", 32'(cdb_valid), 32'h0);
    applyStimulus();
    checkOutput("after_reset_valid_b", 32'(cdb_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
